// File: rtl/buffer_stream_reader.sv
// Frame reader: walks every block of every bank and streams one byte per bank per beat downstream.
// Latency: first beat READ_LATENCY+1 cycles after start; one beat per cycle when unstalled.
// Backpressure: reads issue only against free FIFO credits, so I_ready low stalls issue with no loss.

module bsr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             pop_vld,
    output logic [CW-1:0]    count
);
    // Small register FIFO; head entry is read straight from storage registers (no fall-through).
    // Latency: a pushed entry is visible one cycle after the push edge.
    // Backpressure: the caller guarantees no push when full; pop is ignored when empty.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign pop_vld = (count != '0);
    assign do_pop  = pop && pop_vld;
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            if (push && !do_pop)      count <= count + 1'b1;
            else if (!push && do_pop) count <= count - 1'b1;
        end
    end
endmodule

module buffer_stream_reader #(
    parameter int BYTES_PER_BLOCK    = 2250,
    parameter int BANK_COUNT         = 6,
    parameter int BLOCK_COUNT        = 2,
    parameter int BLOCK_DATA_WIDTH_B = 8,
    parameter int ADDRESS_NUMBER_B   = (BYTES_PER_BLOCK * 8) / BLOCK_DATA_WIDTH_B,
    parameter int AW_B               = $clog2(ADDRESS_NUMBER_B),
    parameter int READ_LATENCY       = 1,
    parameter int FIFO_DEPTH         = READ_LATENCY + 1
) (
    input  logic                                            I_clk,
    input  logic                                            I_reset,
    input  logic                                            I_start,
    output logic                                            O_busy,
    output logic                                            O_done,
    output logic                                            O_ceb,
    output logic [BANK_COUNT*BLOCK_COUNT*AW_B-1:0]          O_adb_flat,
    input  logic [BANK_COUNT*BLOCK_COUNT*BLOCK_DATA_WIDTH_B-1:0] I_dout_flat,
    output logic [BANK_COUNT*BLOCK_DATA_WIDTH_B-1:0]        O_data_flat,
    output logic                                            O_valid,
    input  logic                                            I_ready,
    output logic                                            O_first,
    output logic                                            O_last
);
    localparam int DW  = BLOCK_DATA_WIDTH_B;
    localparam int BW  = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1;
    localparam int CRW = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
    localparam int FW  = BANK_COUNT * DW + 2;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW_B-1:0] ADDR_LAST = AW_B'(ADDRESS_NUMBER_B - 1);
    localparam logic [BW-1:0]   BLK_LAST  = BW'(BLOCK_COUNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                   state;
    logic [AW_B-1:0]          addr;
    logic [BW-1:0]            blk;
    logic                     done;
    logic [READ_LATENCY-1:0]  vld_sr;
    logic [READ_LATENCY-1:0]  first_sr;
    logic [READ_LATENCY-1:0]  last_sr;
    logic [BW-1:0]            blk_sr [READ_LATENCY];
    logic [FCW-1:0]           fifo_count;
    logic [CRW-1:0]           inflight;
    logic [CRW-1:0]           used;
    logic                     issue;
    logic                     is_first;
    logic                     is_last;
    logic                     pop;
    logic                     fifo_vld;
    logic [FW-1:0]            fifo_out;
    logic [BANK_COUNT*DW-1:0] lane_dat;

    assign is_first = (addr == '0) && (blk == '0);
    assign is_last  = (addr == ADDR_LAST) && (blk == BLK_LAST);
    assign pop      = fifo_vld && I_ready;
    // Credits already spent: entries held plus reads still in the BSRAM pipe, less the one leaving now.
    assign used     = CRW'(fifo_count) + inflight - CRW'(pop);
    assign issue    = (state == S_RUN) && (used < CRW'(FIFO_DEPTH));

    assign O_ceb       = issue;
    assign O_busy      = (state != S_IDLE);
    assign O_done      = done;
    assign O_adb_flat  = {(BANK_COUNT * BLOCK_COUNT){addr}};
    assign O_valid     = fifo_vld;
    assign O_data_flat = fifo_out[BANK_COUNT*DW-1:0];
    assign O_first     = fifo_out[FW-2];
    assign O_last      = fifo_out[FW-1];

    // Count reads currently travelling through the BSRAM read pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CRW'(vld_sr[i]);
    end

    // Pick each bank's byte from the block that was addressed READ_LATENCY cycles ago.
    always_comb begin
        lane_dat = '0;
        for (int i = 0; i < BANK_COUNT; i++)
            lane_dat[i*DW +: DW] = I_dout_flat[(i*BLOCK_COUNT + int'(blk_sr[READ_LATENCY-1]))*DW +: DW];
    end

    // Frame sequencer: address/block walk, run-to-drain on the final read, done on empty pipeline.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state <= S_IDLE;
            addr  <= '0;
            blk   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (I_start) begin
                        state <= S_RUN;
                        addr  <= '0;
                        blk   <= '0;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (is_last) begin
                            state <= S_DRAIN;
                        end else if (addr == ADDR_LAST) begin
                            addr <= '0;
                            blk  <= blk + 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fifo_count == '0 && inflight == '0) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Valid, block index and frame tags ride alongside each read for READ_LATENCY cycles.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            vld_sr   <= '0;
            first_sr <= '0;
            last_sr  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) blk_sr[i] <= '0;
        end else begin
            vld_sr[0]   <= issue;
            first_sr[0] <= is_first;
            last_sr[0]  <= is_last;
            blk_sr[0]   <= blk;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i]   <= vld_sr[i-1];
                first_sr[i] <= first_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
                blk_sr[i]   <= blk_sr[i-1];
            end
        end
    end

    bsr_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CW    (FCW)
    ) u_fifo (
        .clk      (I_clk),
        .rst      (I_reset),
        .push     (vld_sr[READ_LATENCY-1]),
        .push_dat ({last_sr[READ_LATENCY-1], first_sr[READ_LATENCY-1], lane_dat}),
        .pop      (pop),
        .pop_dat  (fifo_out),
        .pop_vld  (fifo_vld),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_buffer_stream_reader.sv
// Bench for buffer_stream_reader: a small latency-3 instance and a full-size latency-1 instance.
// Each instance sees a fixed-latency BSRAM model; a per-instance scoreboard tracks the frame.
// Ready is driven constant, patterned, held low or randomized.
`timescale 1ns/1ps
module tb_buffer_stream_reader;
    localparam int A_NB = 2, A_NK = 2, A_AN = 4, A_L = 3;
    localparam int A_AW = $clog2(A_AN);
    localparam int B_NB = 6, B_NK = 2, B_AN = 2250, B_L = 1;
    localparam int B_AW = $clog2(B_AN);

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] bval(input int bank, input int blk, input int a);
        return 8'(bank * 50 + blk * 100 + a * 3 + a / 256);
    endfunction

    logic rst_s [2];
    logic start_s [2];
    logic ready_s [2];

    logic busy_a, done_a, ceb_a, valid_a, first_a, last_a;
    logic [A_NB*A_NK*A_AW-1:0] adb_a;
    logic [A_NB*A_NK*8-1:0]    dout_a;
    logic [A_NB*8-1:0]         data_a;
    logic busy_b, done_b, ceb_b, valid_b, first_b, last_b;
    logic [B_NB*B_NK*B_AW-1:0] adb_b;
    logic [B_NB*B_NK*8-1:0]    dout_b;
    logic [B_NB*8-1:0]         data_b;

    buffer_stream_reader #(.BYTES_PER_BLOCK(4), .BANK_COUNT(A_NB), .BLOCK_COUNT(A_NK),
                           .READ_LATENCY(A_L)) dut_a (
        .I_clk(clk), .I_reset(rst_s[0]), .I_start(start_s[0]), .O_busy(busy_a), .O_done(done_a),
        .O_ceb(ceb_a), .O_adb_flat(adb_a), .I_dout_flat(dout_a), .O_data_flat(data_a),
        .O_valid(valid_a), .I_ready(ready_s[0]), .O_first(first_a), .O_last(last_a));

    buffer_stream_reader #(.BYTES_PER_BLOCK(2250), .BANK_COUNT(B_NB), .BLOCK_COUNT(B_NK),
                           .READ_LATENCY(B_L)) dut_b (
        .I_clk(clk), .I_reset(rst_s[1]), .I_start(start_s[1]), .O_busy(busy_b), .O_done(done_b),
        .O_ceb(ceb_b), .O_adb_flat(adb_b), .I_dout_flat(dout_b), .O_data_flat(data_b),
        .O_valid(valid_b), .I_ready(ready_s[1]), .O_first(first_b), .O_last(last_b));

    // BSRAM models: fixed latency, 8'hEE when the slot carried no read.
    logic [A_NB*A_NK*A_AW-1:0] pa_a [A_L];
    logic                      pv_a [A_L];
    logic [B_NB*B_NK*B_AW-1:0] pa_b [B_L];
    logic                      pv_b [B_L];
    initial begin
        for (int i = 0; i < A_L; i++) pv_a[i] = 1'b0;
        for (int i = 0; i < B_L; i++) pv_b[i] = 1'b0;
    end
    always @(posedge clk) begin
        pa_a[0] <= adb_a;
        pv_a[0] <= ceb_a;
        for (int i = 1; i < A_L; i++) begin pa_a[i] <= pa_a[i-1]; pv_a[i] <= pv_a[i-1]; end
        pa_b[0] <= adb_b;
        pv_b[0] <= ceb_b;
        for (int i = 1; i < B_L; i++) begin pa_b[i] <= pa_b[i-1]; pv_b[i] <= pv_b[i-1]; end
    end
    always_comb begin
        dout_a = '0;
        for (int j = 0; j < A_NB*A_NK; j++)
            dout_a[j*8 +: 8] = pv_a[A_L-1] ? bval(j / A_NK, j % A_NK, int'(pa_a[A_L-1][j*A_AW +: A_AW])) : 8'hEE;
    end
    always_comb begin
        dout_b = '0;
        for (int j = 0; j < B_NB*B_NK; j++)
            dout_b[j*8 +: 8] = pv_b[B_L-1] ? bval(j / B_NK, j % B_NK, int'(pa_b[B_L-1][j*B_AW +: B_AW])) : 8'hEE;
    end

    // Ready policy: 0 always, 1 pattern 1,0,0,1, 2 random, 3 held low.
    int rmode [2] = '{0, 0};
    int ph [2] = '{0, 0};
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            case (rmode[k])
                0: ready_s[k] = 1'b1;
                1: ready_s[k] = (ph[k] % 4 == 0) || (ph[k] % 4 == 3);
                2: ready_s[k] = ($urandom_range(0, 3) != 0);
                default: ready_s[k] = 1'b0;
            endcase
            ph[k]++;
        end
    end

    // Scoreboard state per instance.
    int c_nb [2]  = '{A_NB, B_NB};
    int c_an [2]  = '{A_AN, B_AN};
    int c_aw [2]  = '{A_AW, B_AW};
    int c_lat [2] = '{A_L, B_L};
    int c_dep [2] = '{A_L + 1, B_L + 1};
    int c_tot [2] = '{A_NK * A_AN, B_NK * B_AN};
    int beat [2], issued [2], popped [2], hs_edge [2], dones [2], start_edge [2], wraps [2], last_addr [2];
    bit first_wait [2], stall_prev [2];
    logic [63:0] prev_word [2];

    task automatic clear(input int k);
        beat[k] = 0; issued[k] = 0; popped[k] = 0; wraps[k] = 0; last_addr[k] = 0;
        hs_edge[k] = -10; stall_prev[k] = 0; first_wait[k] = 0;
    endtask

    task automatic mon(input int k, input logic valid, input logic ready, input logic first,
                       input logic last, input logic done, input logic busy, input logic ceb,
                       input logic [143:0] adb, input logic [47:0] data);
        logic [63:0] word, mask, a_j;
        logic [47:0] expw;
        int pop;
        word = {14'b0, last, first, data};
        pop  = (valid && ready) ? 1 : 0;
        if (done) begin
            check("done_timing", cyc, hs_edge[k] + 1);
            check("done_idle", busy, 0);
            check("done_beats", beat[k], c_tot[k]);
            dones[k]++;
        end
        if (stall_prev[k]) begin
            check("hold_valid", valid, 1);
            check("hold_word", word, prev_word[k]);
        end
        if (first_wait[k] && valid) begin
            check("first_latency", cyc - start_edge[k], c_lat[k] + 1);
            first_wait[k] = 0;
        end
        if (ceb) begin
            check("busy_on_read", busy, 1);
            check("credit", (issued[k] - popped[k] - pop) < c_dep[k], 1);
            check("read_count", issued[k] < c_tot[k], 1);
            mask = (64'd1 << c_aw[k]) - 64'd1;
            for (int j = 0; j < c_nb[k] * 2; j++) begin
                a_j = 64'(adb >> (j * c_aw[k])) & mask;
                check("read_addr", a_j, issued[k] % c_an[k]);
            end
            a_j = 64'(adb) & mask;
            if (issued[k] > 0 && int'(a_j) < last_addr[k]) wraps[k]++;
            last_addr[k] = int'(a_j);
            issued[k]++;
        end
        if (pop == 1) begin
            expw = '0;
            for (int i = 0; i < c_nb[k]; i++) expw[i*8 +: 8] = bval(i, beat[k] / c_an[k], beat[k] % c_an[k]);
            check("beat_in_frame", beat[k] < c_tot[k], 1);
            check("beat_word", word, {14'b0, beat[k] == c_tot[k] - 1, beat[k] == 0, expw});
            hs_edge[k] = cyc + 1;
            beat[k]++;
            popped[k]++;
        end
        stall_prev[k] = valid && !ready;
        prev_word[k]  = word;
    endtask

    always @(negedge clk) begin
        if (!rst_s[0]) mon(0, valid_a, ready_s[0], first_a, last_a, done_a, busy_a, ceb_a, 144'(adb_a), 48'(data_a));
        if (!rst_s[1]) mon(1, valid_b, ready_s[1], first_b, last_b, done_b, busy_b, ceb_b, 144'(adb_b), data_b);
    end

    task automatic check_idle(input int k);
        if (k == 0) begin
            check("rst_ctrl_a", {busy_a, done_a, ceb_a, valid_a, first_a, last_a}, 0);
            check("rst_adb_a", adb_a, 0);
            check("rst_data_a", data_a, 0);
        end else begin
            check("rst_ctrl_b", {busy_b, done_b, ceb_b, valid_b, first_b, last_b}, 0);
            check("rst_adb_b", |adb_b, 0);
            check("rst_data_b", data_b, 0);
        end
    endtask

    task automatic start_frame(input int k);
        @(posedge clk); #1;
        clear(k);
        first_wait[k] = 1;
        start_edge[k] = cyc + 1;
        start_s[k] = 1'b1;
        @(posedge clk); #1;
        start_s[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int limit);
        int d0;
        int n;
        d0 = dones[k];
        n = 0;
        while (dones[k] == d0 && n < limit) begin @(posedge clk); n++; end
        check("frame_end", dones[k] - d0, 1);
        check("frame_beats", beat[k], c_tot[k]);
    endtask

    task automatic do_reset(input int k);
        @(posedge clk); #1;
        rst_s[k] = 1'b1;
        #1;
        check_idle(k);
        repeat (2) @(posedge clk);
        #1;
        rst_s[k] = 1'b0;
        clear(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rst_s[0] = 1'b1; rst_s[1] = 1'b1;
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        dones[0] = 0; dones[1] = 0;
        clear(0); clear(1);
        repeat (3) @(posedge clk);
        #1;
        check_idle(0);
        check_idle(1);
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;

        // Small instance, ready always high, then the 1,0,0,1 pattern.
        start_frame(0);
        wait_done(0, 200);
        rmode[0] = 1;
        start_frame(0);
        wait_done(0, 200);

        // Ready held low: exactly FIFO_DEPTH reads, then issue stops.
        rmode[0] = 3;
        start_frame(0);
        repeat (20) @(posedge clk);
        #1;
        check("stall_reads", issued[0], A_L + 1);
        check("stall_ceb", ceb_a, 0);
        rmode[0] = 0;
        wait_done(0, 200);

        // Start pulsed again while running is ignored.
        rmode[0] = 2;
        start_frame(0);
        repeat (3) @(posedge clk);
        #1;
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        wait_done(0, 300);
        d = dones[0];
        repeat (30) @(posedge clk);
        #1;
        check("restart_ignored", dones[0] - d, 0);
        check("restart_beats", beat[0], c_tot[0]);
        check("restart_idle", busy_a, 0);

        // Reset in the middle of a frame, then a clean frame from block 0 addr 0.
        rmode[0] = 0;
        start_frame(0);
        for (int n = 0; n < 200 && beat[0] < 3; n++) @(posedge clk);
        do_reset(0);
        start_frame(0);
        wait_done(0, 200);

        // Random ready and random idle gaps.
        for (int r = 0; r < 6; r++) begin
            rmode[0] = $urandom_range(1, 2);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            start_frame(0);
            wait_done(0, 400);
        end

        // Full-size instance, free-flowing and then random ready.
        rmode[1] = 0;
        start_frame(1);
        wait_done(1, 6000);
        check("addr_wraps_b", wraps[1], 1);
        rmode[1] = 2;
        start_frame(1);
        wait_done(1, 20000);
        check("addr_wraps_b_rand", wraps[1], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
